// File: rtl/mmix_defs.sv
// Shared MMIX pipeline types: operand descriptors, register-file responses,
// register-write traffic and the operand-fetch FSM state encoding.
package mmix_defs;

  localparam int OPF_NSLOT = 4;
  localparam int OPF_DW    = 64;
  localparam int OPF_AW    = 8;

  // src == 0 selects the immediate o; src[0] global file, src[1] local file.
  typedef struct packed {
    logic [1:0]        src;
    logic [OPF_AW-1:0] addr;
    logic [OPF_DW-1:0] o;
  } spec_t;

  typedef struct packed {
    logic [OPF_DW-1:0] data;
    logic              valid;
  } spec_val_t;

  typedef struct packed {
    logic              enable;
    logic [OPF_AW-1:0] addr;
    logic [OPF_DW-1:0] data;
  } regwrite_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } opf_state_e;

  function automatic logic rw_hit(regwrite_t rw, logic sel, logic [OPF_AW-1:0] addr);
    return rw.enable & sel & (rw.addr == addr);
  endfunction

endpackage

// File: rtl/opf_slot.sv
// One operand slot: got flag plus sticky data register. With OPF_BYPASS_EN
// defined, in-flight register writes are snooped ahead of the file response.
module opf_slot
  import mmix_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              fetch_i,
  input  spec_t             spec_i,
  input  spec_val_t         val_i,
  input  regwrite_t         gregw_i,
  input  regwrite_t         lregw_i,
  output logic              got_d_o,
  output logic [OPF_DW-1:0] data_o
);

  logic              got_q, got_d;
  logic [OPF_DW-1:0] data_q, data_d;

`ifdef OPF_BYPASS_EN
  logic g_hit, l_hit;
  assign g_hit = rw_hit(gregw_i, spec_i.src[0], spec_i.addr);
  assign l_hit = rw_hit(lregw_i, spec_i.src[1], spec_i.addr);
`else
  logic rw_unused;
  assign rw_unused = ^{gregw_i, lregw_i};
`endif

  always_comb begin
    got_d  = got_q;
    data_d = data_q;
    if (clear_i) begin
      got_d = 1'b0;
    end else if (fetch_i && !got_q) begin
`ifdef OPF_BYPASS_EN
      if (g_hit) begin
        got_d  = 1'b1;
        data_d = gregw_i.data;
      end else if (l_hit) begin
        got_d  = 1'b1;
        data_d = lregw_i.data;
      end else if (val_i.valid) begin
        got_d  = 1'b1;
        data_d = val_i.data;
      end
`else
      if (val_i.valid) begin
        got_d  = 1'b1;
        data_d = val_i.data;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      got_q  <= 1'b0;
      data_q <= '0;
    end else begin
      got_q  <= got_d;
      data_q <= data_d;
    end
  end

  assign got_d_o = got_d;
  assign data_o  = data_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts a decoded instruction, collects four operands
// from the register file and holds the bundle until downstream takes it.
// Optional register-write bypass is enabled by defining OPF_BYPASS_EN.
module operand_fetch
  import mmix_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_op,
  input  spec_t             in_y,
  input  spec_t             in_z,
  input  spec_t             in_b,
  input  spec_t             in_ra,
  output spec_t             y,
  output spec_t             z,
  output spec_t             b,
  output spec_t             ra,
  input  spec_val_t         y_val,
  input  spec_val_t         z_val,
  input  spec_val_t         b_val,
  input  spec_val_t         ra_val,
  input  regwrite_t         gregw,
  input  regwrite_t         lregw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_op,
  output logic [OPF_DW-1:0] out_y,
  output logic [OPF_DW-1:0] out_z,
  output logic [OPF_DW-1:0] out_b,
  output logic [OPF_DW-1:0] out_ra,
  input  logic              flush
);

  opf_state_e                          state_q;
  logic                                in_ready_q, out_valid_q;
  logic [7:0]                          op_q;
  spec_t     [OPF_NSLOT-1:0]           spec_q, in_spec_w;
  spec_val_t [OPF_NSLOT-1:0]           val_w;
  logic      [OPF_NSLOT-1:0]           got_d_w;
  logic      [OPF_NSLOT-1:0][OPF_DW-1:0] data_w;
  logic                                accept_w, clear_w, fetch_w, all_got_w;

  assign in_spec_w = {in_ra, in_b, in_z, in_y};
  assign val_w     = {ra_val, b_val, z_val, y_val};

  assign accept_w  = (state_q == S_IDLE) && in_valid && !flush;
  assign clear_w   = flush || accept_w;
  assign fetch_w   = (state_q == S_FETCH);
  // Next-state got flags: HOLD is entered on the edge that captures the last operand.
  assign all_got_w = &got_d_w;

  for (genvar i = 0; i < OPF_NSLOT; i++) begin : g_slot
    opf_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear_w),
      .fetch_i (fetch_w),
      .spec_i  (spec_q[i]),
      .val_i   (val_w[i]),
      .gregw_i (gregw),
      .lregw_i (lregw),
      .got_d_o (got_d_w[i]),
      .data_o  (data_w[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      spec_q      <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      spec_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q       <= in_op;
          spec_q     <= in_spec_w;
          state_q    <= S_FETCH;
          in_ready_q <= 1'b0;
        end
        S_FETCH: if (all_got_w) begin
          state_q     <= S_HOLD;
          out_valid_q <= 1'b1;
        end
        S_HOLD: if (out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          spec_q      <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          spec_q      <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_op    = op_q;
  assign y         = spec_q[0];
  assign z         = spec_q[1];
  assign b         = spec_q[2];
  assign ra        = spec_q[3];
  assign out_y     = data_w[0];
  assign out_z     = data_w[1];
  assign out_b     = data_w[2];
  assign out_ra    = data_w[3];

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: vector table for the basic flow plus
// hand-written sequences for stalls, sticky capture, hold, flush and bypass.
module tb_operand_fetch;
  import mmix_defs::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0]  in_op, out_op;
  spec_t       in_y, in_z, in_b, in_ra, y, z, b, ra;
  spec_val_t   y_val, z_val, b_val, ra_val;
  regwrite_t   gregw, lregw;
  logic [63:0] out_y, out_z, out_b, out_ra;

  logic        rf_v [4];
  logic [63:0] rf_d [4];
  int n_pass  = 0;
  int n_total = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_y(in_y), .in_z(in_z), .in_b(in_b), .in_ra(in_ra),
    .y(y), .z(z), .b(b), .ra(ra),
    .y_val(y_val), .z_val(z_val), .b_val(b_val), .ra_val(ra_val),
    .gregw(gregw), .lregw(lregw), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_y(out_y), .out_z(out_z), .out_b(out_b), .out_ra(out_ra),
    .flush(flush)
  );

  // Register file model: immediate path for src==0, otherwise bench-driven.
  always_comb begin
    y_val  = (y.src  == 2'd0) ? {y.o,  1'b1} : {rf_d[0], rf_v[0]};
    z_val  = (z.src  == 2'd0) ? {z.o,  1'b1} : {rf_d[1], rf_v[1]};
    b_val  = (b.src  == 2'd0) ? {b.o,  1'b1} : {rf_d[2], rf_v[2]};
    ra_val = (ra.src == 2'd0) ? {ra.o, 1'b1} : {rf_d[3], rf_v[3]};
  end

  typedef struct {
    logic [7:0]  op;
    spec_t       sy, sz, sb, sra;
    logic [63:0] rfd;
    logic [63:0] ey, ez, eb, era;
  } vec_t;
  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic spec_t mk(input logic [1:0] s, input logic [7:0] a, input logic [63:0] o);
    spec_t r;
    r.src = s; r.addr = a; r.o = o;
    return r;
  endfunction

  task automatic step();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic set_rf(input logic v, input logic [63:0] d);
    for (int i = 0; i < 4; i++) begin rf_v[i] = v; rf_d[i] = d; end
  endtask

  // Leaves the bench at the falling edge of the first FETCH cycle.
  task automatic accept(input logic [7:0] op, input spec_t sy, input spec_t sz,
                        input spec_t sb, input spec_t sra);
    @(negedge clk);
    in_op = op; in_y = sy; in_z = sz; in_b = sb; in_ra = sra; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_op = '0;
    in_y = '0; in_z = '0; in_b = '0; in_ra = '0; gregw = '0; lregw = '0;
    set_rf(1'b0, 64'h0);

    vecs[0] = '{8'h10, mk(0,0,1), mk(0,0,2), mk(0,0,3), mk(0,0,4), 64'h0,
                64'd1, 64'd2, 64'd3, 64'd4};
    vecs[1] = '{8'hFF, mk(1,5,0), mk(0,0,64'hFFFF_FFFF_FFFF_FFFF), mk(0,0,7), mk(0,0,8),
                64'hABCD, 64'hABCD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd8};
    vecs[2] = '{8'h00, mk(2,1,9), mk(2,2,9), mk(2,3,9), mk(2,4,9), 64'h1234,
                64'h1234, 64'h1234, 64'h1234, 64'h1234};
    vecs[3] = '{8'h5A, mk(0,0,64'h8000_0000_0000_0000), mk(1,8'h33,0), mk(3,8'h44,0), mk(0,0,0),
                64'h99, 64'h8000_0000_0000_0000, 64'h99, 64'h99, 64'h0};

    step(); step();
    chk("rst_in_ready", in_ready, 1); chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op", out_op, 0);     chk("rst_out_y", out_y, 0);
    chk("rst_out_ra", out_ra, 0);     chk("rst_y_spec", y.o, 0);
    reset = 1'b0;

    // Basic flow, two-cycle latency, immediate release
    foreach (vecs[i]) begin
      set_rf(1'b1, vecs[i].rfd);
      out_ready = 1'b1;
      accept(vecs[i].op, vecs[i].sy, vecs[i].sz, vecs[i].sb, vecs[i].sra);
      chk("tbl_fetch_in_ready", in_ready, 0);
      chk("tbl_fetch_out_valid", out_valid, 0);
      chk("tbl_fetch_z_addr", z.addr, vecs[i].sz.addr);
      step();
      chk("tbl_out_valid", out_valid, 1); chk("tbl_out_op", out_op, vecs[i].op);
      chk("tbl_out_y", out_y, vecs[i].ey); chk("tbl_out_z", out_z, vecs[i].ez);
      chk("tbl_out_b", out_b, vecs[i].eb); chk("tbl_out_ra", out_ra, vecs[i].era);
      step();
      chk("tbl_idle_in_ready", in_ready, 1); chk("tbl_idle_out_valid", out_valid, 0);
      chk("tbl_idle_y_addr", y.addr, 0);
    end

    // y stalls three FETCH cycles, valid in the fourth
    set_rf(1'b0, 64'h0);
    accept(8'h21, mk(1,5,0), mk(0,0,1), mk(0,0,2), mk(0,0,3));
    for (int c = 0; c < 3; c++) begin
      chk("stall_out_valid", out_valid, 0);
      step();
    end
    rf_v[0] = 1'b1; rf_d[0] = 64'hDEAD;
    chk("stall_valid_cycle_ov", out_valid, 0);
    step();
    chk("stall_out_valid_after", out_valid, 1); chk("stall_out_y", out_y, 64'hDEAD);
    step();
    chk("stall_released", in_ready, 1);

    // z captured early is sticky; then hold with out_ready low
    set_rf(1'b0, 64'h0);
    out_ready = 1'b0;
    rf_v[1] = 1'b1; rf_d[1] = 64'h11;
    accept(8'h31, mk(0,0,5), mk(1,7,0), mk(2,9,0), mk(0,0,6));
    step();
    rf_d[1] = 64'h22;
    chk("sticky_pending_ov", out_valid, 0);
    step();
    rf_v[2] = 1'b1; rf_d[2] = 64'h33;
    step();
    for (int c = 0; c < 4; c++) begin
      chk("hold_out_valid", out_valid, 1); chk("hold_in_ready", in_ready, 0);
      chk("hold_out_z_sticky", out_z, 64'h11); chk("hold_out_b", out_b, 64'h33);
      chk("hold_out_op", out_op, 8'h31);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("hold_release_in_ready", in_ready, 1); chk("hold_release_ov", out_valid, 0);

    // flush during FETCH, then a normal instruction
    set_rf(1'b0, 64'h0);
    accept(8'h41, mk(1,3,0), mk(0,0,1), mk(0,0,2), mk(0,0,3));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_fetch_ov", out_valid, 0); chk("flush_fetch_in_ready", in_ready, 1);
    chk("flush_fetch_y_addr", y.addr, 0);
    accept(8'h42, mk(0,0,64'hA), mk(0,0,64'hB), mk(0,0,64'hC), mk(0,0,64'hD));
    step();
    chk("post_flush_ov", out_valid, 1); chk("post_flush_out_ra", out_ra, 64'hD);
    step();

    // flush during HOLD, then a stalled instruction must not complete early
    out_ready = 1'b0;
    accept(8'h51, mk(0,0,1), mk(0,0,2), mk(0,0,3), mk(0,0,4));
    step();
    chk("flush_hold_pre_ov", out_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_hold_ov", out_valid, 0); chk("flush_hold_in_ready", in_ready, 1);
    out_ready = 1'b1;
    accept(8'h52, mk(1,6,0), mk(0,0,1), mk(0,0,2), mk(0,0,3));
    step();
    chk("flush_hold_new_ov0", out_valid, 0);
    step();
    chk("flush_hold_new_ov1", out_valid, 0);
    rf_v[0] = 1'b1; rf_d[0] = 64'h77;
    step();
    chk("flush_hold_new_done", out_valid, 1); chk("flush_hold_new_y", out_y, 64'h77);
    step();
    set_rf(1'b0, 64'h0);

    // global-write bypass with the file response withheld
    gregw = '{enable: 1'b1, addr: 8'h20, data: 64'h55};
    accept(8'h61, mk(1,8'h20,0), mk(0,0,0), mk(0,0,0), mk(0,0,0));
    step();
`ifdef OPF_BYPASS_EN
    chk("bypass_ov", out_valid, 1); chk("bypass_out_y", out_y, 64'h55);
    step();
`else
    chk("nobypass_ov", out_valid, 0); chk("nobypass_in_ready", in_ready, 0);
    step();
    chk("nobypass_still_fetch", out_valid, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
`endif
    gregw = '0;
    chk("bypass_end_idle", in_ready, 1);

    // reset overrides flush and handshakes in HOLD
    out_ready = 1'b0;
    accept(8'h71, mk(0,0,9), mk(0,0,9), mk(0,0,9), mk(0,0,9));
    step();
    chk("rst2_pre_ov", out_valid, 1);
    reset = 1'b1; flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    step();
    chk("rst2_in_ready", in_ready, 1); chk("rst2_ov", out_valid, 0);
    chk("rst2_out_op", out_op, 0);     chk("rst2_out_y", out_y, 0);
    chk("rst2_z_spec", z.o, 0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, a decoded instruction is offered.
REQ-004 SHALL have port in_ready, output, 1, the block accepts the offered instruction.
REQ-005 SHALL have port in_op, input, 8, opcode carried through unchanged.
REQ-006 SHALL have ports in_y, in_z, in_b, in_ra, input, spec each, operand descriptors (src[1:0], addr[7:0], o[63:0]).
REQ-007 SHALL have ports y, z, b, ra, output, spec each, descriptors presented to the register file.
REQ-008 SHALL have ports y_val, z_val, b_val, ra_val, input, spec_val each, register-file responses (data[63:0], valid).
REQ-009 SHALL have ports gregw, lregw, input, regwrite each, write traffic (enable, addr[7:0], data[63:0]); used only by the bypass feature.
REQ-010 SHALL have port out_valid, output, 1, operand bundle available.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the bundle.
REQ-012 SHALL have ports out_op (8), out_y, out_z, out_b, out_ra (64 each), outputs, bundle contents.
REQ-013 SHALL have port flush, input, 1, discard the in-flight instruction.

Function
REQ-014 SHALL implement FSM IDLE, FETCH, HOLD.
REQ-015 In IDLE, in_ready SHALL be 1; on in_valid it SHALL latch in_op and the four specs, clear all per-operand got flags and go to FETCH.
REQ-016 In FETCH and HOLD, in_ready SHALL be 0; y/z/b/ra SHALL drive the latched specs; in IDLE they SHALL drive src=0, addr=0, o=0.
REQ-017 In FETCH, each operand whose got flag is 0 and whose *_val.valid is 1 SHALL capture *_val.data and set got; captured data SHALL be sticky until the next accept.
REQ-018 An operand with src=0 SHALL be satisfied by the register file's immediate path (valid=1, data=o), captured in the first FETCH cycle.
REQ-019 When all four got flags are 1 at a clock edge, the FSM SHALL go to HOLD with out_valid=1 in the next cycle; minimum latency from acceptance to out_valid is 2 cycles.
REQ-020 In HOLD, out_* SHALL stay stable until out_valid & out_ready; then it SHALL go to IDLE (no accept in the same cycle).
REQ-021 flush SHALL force IDLE at the next edge from any state and clear out_valid and the got flags; flush has priority over capture and handshake.
REQ-022 out_valid SHALL be 1 only in HOLD.

Reset
REQ-023 On reset: state=IDLE, in_ready=1, out_valid=0, got flags=0, out_op=0, out_y/z/b/ra=0, latched specs=0.
REQ-024 Reset SHALL override flush and all handshakes in the same cycle.

Configuration
REQ-025 With OPF_BYPASS_EN defined, an uncaptured operand in FETCH SHALL also capture gregw.data when gregw.enable, src[0] and addr match. It SHALL likewise capture lregw.data when lregw.enable, src[1] and addr match. Bypass SHALL take priority over *_val in the same cycle.
REQ-026 Without OPF_BYPASS_EN, gregw/lregw SHALL be ignored and capture SHALL come only from *_val.

Structure
REQ-027 spec, spec_val and regwrite typedefs and the FSM state enum SHALL live in the shared mmix_defs package.
REQ-028 Per-operand capture (got flag, data register, bypass compare) SHALL be a sub-module opf_slot, instantiated four times.

Verification
REQ-029 Case: all four src=0, o=1,2,3,4, out_ready=1. Required: out_valid rises 2 cycles after accept with out_y..out_ra = 1,2,3,4, then IDLE.
REQ-030 Case: y from global reg 5 with y_val.valid held 0 for 3 FETCH cycles, then valid with data 0xDEAD. Required: out_y=0xDEAD and out_valid is 1 in the cycle after the valid cycle.
REQ-031 Case: z valid in FETCH cycle 1 with 0x11, then z_val data changes to 0x22 while b is still pending. Required: out_z=0x11 (sticky).
REQ-032 Case: HOLD with out_ready=0 for 4 cycles. Required: out_* stable and in_ready=0 throughout; out_ready=1 gives IDLE next cycle.
REQ-033 Case: flush in FETCH, and separately flush in HOLD. Required: out_valid=0 and IDLE next cycle; a new instruction is then accepted normally.
REQ-034 Case (OPF_BYPASS_EN): y src[0] addr 0x20 with y_val.valid=0, and gregw enable=1, addr 0x20, data 0x55. Required: out_y=0x55; without the macro the block stays in FETCH.
